// File: rtl/symbol_overlay_pkg.sv
// Shared types and constants for the symbol overlay unit: scan FSM states,
// default class colours and the class -> colour mapping.
package symbol_overlay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } scan_state_e;

  // Colours as {r,g,b} channel-enable masks; a set bit means full intensity.
  localparam logic [2:0] COL_YELLOW = 3'b110;
  localparam logic [2:0] COL_GREEN  = 3'b010;
  localparam logic [2:0] COL_BLUE   = 3'b001;
  localparam logic [2:0] COL_RED    = 3'b100;

  // Default colour of a class; classes beyond 3 reuse the first four colours.
  function automatic logic [2:0] default_colour(input int cls);
    case (cls % 4)
      0:       return COL_YELLOW;
      1:       return COL_GREEN;
      2:       return COL_BLUE;
      default: return COL_RED;
    endcase
  endfunction

endpackage

// File: rtl/score_argmax_scan.sv
// Sequential argmax over N_CLASSES signed scores. Latches the score vector on
// an accepted strobe, examines one class per cycle, then presents the winning
// class (or N_CLASSES for none) for one COMMIT cycle.
module score_argmax_scan
  import symbol_overlay_pkg::*;
#(
  parameter int N_CLASSES = 4,
  parameter int SCORE_W   = 32,
  parameter int THRESHOLD = 127
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          score_valid_i,
  input  logic [N_CLASSES*SCORE_W-1:0]  scores_i,
  output logic                          busy_o,
  output logic                          drop_o,
  output logic [$clog2(N_CLASSES+1)-1:0] result_o,
  output logic                          result_valid_o
);

  localparam int CLS_W = $clog2(N_CLASSES + 1);
  localparam int IDX_W = $clog2(N_CLASSES);
  localparam logic [CLS_W-1:0] NONE = CLS_W'(N_CLASSES);
  localparam logic signed [SCORE_W-1:0] THR = SCORE_W'(THRESHOLD);

  scan_state_e               state_q;
  logic [IDX_W-1:0]          idx_q;
  logic [CLS_W-1:0]          best_cls_q;
  logic                      drop_q;
  logic signed [SCORE_W-1:0] score_q [N_CLASSES];
  logic signed [SCORE_W-1:0] best_score_q;

  logic signed [SCORE_W-1:0] cur_score;
  logic                      take;
  logic                      last;

  // Strict signed compares: equal scores never displace an earlier class.
  always_comb begin
    cur_score = score_q[idx_q];
    take      = (cur_score > THR) && ((best_cls_q == NONE) || (cur_score > best_score_q));
    last      = (idx_q == IDX_W'(N_CLASSES - 1));
  end

  // Scan FSM; a strobe arriving while not IDLE is reported as dropped next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      best_cls_q <= NONE;
      drop_q     <= 1'b0;
    end else begin
      drop_q <= score_valid_i && (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (score_valid_i) begin
            state_q    <= ST_SCAN;
            idx_q      <= '0;
            best_cls_q <= NONE;
          end
        end
        ST_SCAN: begin
          if (take) best_cls_q <= CLS_W'(idx_q);
          idx_q <= idx_q + 1'b1;
          if (last) state_q <= ST_COMMIT;
        end
        ST_COMMIT: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // Score storage and running best score; meaningful only while the FSM uses them.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && score_valid_i) begin
      for (int i = 0; i < N_CLASSES; i++) begin
        score_q[i] <= scores_i[i*SCORE_W +: SCORE_W];
      end
    end else if (state_q == ST_SCAN && take) begin
      best_score_q <= cur_score;
    end
  end

  assign busy_o         = (state_q != ST_IDLE);
  assign drop_o         = drop_q;
  assign result_o       = best_cls_q;
  assign result_valid_o = (state_q == ST_COMMIT);

endmodule

// File: rtl/symbol_overlay_unit.sv
// Symbol overlay: debounces the argmax class over CONFIRM identical score
// updates and colours the grey pixel stream with the confirmed class's palette
// entry, or a lightened grey when no class is confirmed.
// Optional feature macro: SYMBOL_OVERLAY_PALETTE_WR_EN (writable palette port).
module symbol_overlay_unit
  import symbol_overlay_pkg::*;
#(
  parameter int N_CLASSES = 4,
  parameter int SCORE_W   = 32,
  parameter int PIX_W     = 8,
  parameter int THRESHOLD = 127,
  parameter int CONFIRM   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
`ifdef SYMBOL_OVERLAY_PALETTE_WR_EN
  input  logic                           pal_we,
  input  logic [$clog2(N_CLASSES)-1:0]   pal_idx,
  input  logic [3*PIX_W-1:0]             pal_rgb,
`endif
  input  logic                           score_valid,
  input  logic [N_CLASSES*SCORE_W-1:0]   scores,
  output logic                           score_busy,
  output logic                           score_drop,
  input  logic                           pix_valid,
  input  logic [PIX_W-1:0]               pix_data,
  output logic                           out_valid,
  output logic [PIX_W-1:0]               r_out,
  output logic [PIX_W-1:0]               g_out,
  output logic [PIX_W-1:0]               b_out,
  output logic [$clog2(N_CLASSES+1)-1:0] active_class
);

  localparam int CLS_W = $clog2(N_CLASSES + 1);
  localparam int CNT_W = $clog2(CONFIRM + 1);
  localparam logic [CLS_W-1:0] NONE = CLS_W'(N_CLASSES);
  localparam logic [CNT_W-1:0] CONF = CNT_W'(CONFIRM);

  function automatic logic [3*PIX_W-1:0] default_rgb(input int cls);
    logic [2:0] m;
    m = default_colour(cls);
    return {{PIX_W{m[2]}}, {PIX_W{m[1]}}, {PIX_W{m[0]}}};
  endfunction

  logic [CLS_W-1:0] res;
  logic             res_valid;

  score_argmax_scan #(
    .N_CLASSES (N_CLASSES),
    .SCORE_W   (SCORE_W),
    .THRESHOLD (THRESHOLD)
  ) u_scan (
    .clk            (clk),
    .rst            (rst),
    .score_valid_i  (score_valid),
    .scores_i       (scores),
    .busy_o         (score_busy),
    .drop_o         (score_drop),
    .result_o       (res),
    .result_valid_o (res_valid)
  );

  logic [CLS_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CLS_W-1:0] active_q, active_d;

  // Debounce: count repeats of the same result; "none" is treated as a class.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (res_valid) begin
      if (res == cand_q) begin
        if (cnt_q != CONF) cnt_d = cnt_q + 1'b1;
      end else begin
        cand_d = res;
        cnt_d  = CNT_W'(1);
      end
      if (cnt_d == CONF) active_d = cand_d;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q   <= NONE;
      cnt_q    <= '0;
      active_q <= NONE;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  logic [3*PIX_W-1:0] pal_entry;

`ifdef SYMBOL_OVERLAY_PALETTE_WR_EN
  logic [3*PIX_W-1:0] pal_q [N_CLASSES];

  // Writable palette, restored to the default colours on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CLASSES; i++) pal_q[i] <= default_rgb(i);
    end else if (pal_we && (int'(pal_idx) < N_CLASSES)) begin
      pal_q[pal_idx] <= pal_rgb;
    end
  end

  assign pal_entry = pal_q[active_q[$clog2(N_CLASSES)-1:0]];
`else
  assign pal_entry = default_rgb(int'(active_q));
`endif

  logic [PIX_W-1:0]   grey;
  logic [3*PIX_W-1:0] sel_rgb;
  logic [1:0]         unused_pix_lsbs;

  assign grey            = {2'b11, pix_data[PIX_W-1:2]};
  assign unused_pix_lsbs = pix_data[1:0];
  assign sel_rgb         = (active_q < NONE) ? pal_entry : {grey, grey, grey};

  logic               out_valid_q;
  logic [3*PIX_W-1:0] rgb_q;

  // Pixel stage: one-cycle latency, colour held while no pixel is qualified.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      rgb_q       <= '0;
    end else begin
      out_valid_q <= pix_valid;
      if (pix_valid) rgb_q <= sel_rgb;
    end
  end

  assign out_valid    = out_valid_q;
  assign r_out        = rgb_q[3*PIX_W-1:2*PIX_W];
  assign g_out        = rgb_q[2*PIX_W-1:PIX_W];
  assign b_out        = rgb_q[PIX_W-1:0];
  assign active_class = active_q;

endmodule

// File: doc/symbol_overlay_unit.md
# symbol_overlay_unit

Parametrised successor to the fixed four-symbol colour overlay: sequentially selects the winning class among `N_CLASSES` classifier scores, debounces it over several score updates, and colours the pixel stream with that class's palette entry. Where no class is confirmed it outputs a lightened grey of the input. Sits between the classifier output stage and the display/VGA driver.

## Interface
Parameters:
- `N_CLASSES`, 4: number of symbol classes (≥2).
- `SCORE_W`, 32: score width, signed two's complement.
- `PIX_W`, 8: input pixel and per-channel output width (≥3).
- `THRESHOLD`, 127: a score counts only if strictly greater.
- `CONFIRM`, 2: consecutive identical results needed before the displayed class changes (≥1).

Ports (one clock `clk`; reset `rst` is asynchronous, active-high):
- `clk` in 1: clock.
- `rst` in 1: async active-high reset.
- `score_valid` in 1: one-cycle strobe, `scores` valid.
- `scores` in `N_CLASSES*SCORE_W`: class i at bits `[i*SCORE_W +: SCORE_W]`.
- `score_busy` out 1: scan in progress.
- `score_drop` out 1: one-cycle pulse, strobe ignored while busy.
- `pix_valid` in 1: pixel qualifier.
- `pix_data` in `PIX_W`: grey pixel.
- `out_valid` out 1: output pixel qualifier.
- `r_out`, `g_out`, `b_out` out `PIX_W` each: colour out.
- `active_class` out `$clog2(N_CLASSES+1)`: displayed class; value `N_CLASSES` = none.
- Palette port, only with `PALETTE_WR_EN`: `pal_we` in 1, `pal_idx` in `$clog2(N_CLASSES)`, `pal_rgb` in `3*PIX_W` ({r,g,b}).

## Operation
- FSM `IDLE` → `SCAN` → `COMMIT` → `IDLE`.
- IDLE: on `score_valid`, latch all scores, set best = none, index = 0, go SCAN.
- SCAN: one class per cycle. Class i replaces best if score_i > THRESHOLD and (best none or score_i > best score, signed). Strict compare, so ties go to the lowest index. After index `N_CLASSES-1`, go COMMIT.
- COMMIT: apply the debounce with result R (a class or none):
  - If R == candidate: count++ (saturate at `CONFIRM`).
  - Else: candidate = R, count = 1.
  - When count reaches `CONFIRM`: `active_class` = candidate.
  - "None" is debounced like any class.
- `score_busy` is high in SCAN and COMMIT. A `score_valid` in those states is ignored and pulses `score_drop` the next cycle. A `score_valid` in the same cycle COMMIT→IDLE occurs is also dropped.
- Pixel path, each cycle with `pix_valid`:
  - If `active_class` < N: output the palette entry.
  - Else: all three channels = {2'b11, `pix_data[PIX_W-1:2]`}.
- Default palette: class 0 yellow (max,max,0), 1 green, 2 blue, 3 red. Classes ≥4 cycle through the same four.

## Timing
- Reset values: `r/g/b_out` 0, `out_valid` 0, `score_busy` 0, `score_drop` 0, `active_class` = N, candidate = N, count 0, palette = defaults, FSM IDLE.
- Score latency: `score_valid` at cycle t → COMMIT at t+N+1 → `active_class` updated visible at t+N+2. Accept rate is one update per N+2 cycles.
- Pixel latency is 1 cycle, no backpressure: `out_valid`(t+1) = `pix_valid`(t). Colour uses `active_class` as registered at t, so a same-cycle class change affects the next pixel.
- While `out_valid` is low, RGB holds its last value.
- With `PALETTE_WR_EN`, a palette write at t affects pixels sampled from t+1.
- Reset mid-scan aborts the scan and discards the pending result.

## Configuration
- `SYMBOL_OVERLAY_PALETTE_WR_EN` defined: palette is a register array with the write port present.
- Not defined: palette is constants from the package, and the write ports are absent.

## Structure
- Package `symbol_overlay_pkg` holds:
  - the FSM state enum;
  - default colour constants;
  - the default-palette function (class → {r,g,b}).
- Sub-module `score_argmax_scan`:
  - contains the IDLE/SCAN/COMMIT FSM, latched scores and best tracking;
  - outputs result plus a one-cycle `result_valid`.
- The top level holds the debounce, palette and pixel path.

## Test plan
- Reset, then `pix_valid`=1, `pix_data`=0xFF → RGB = 0xFF/0xFF/0xFF, `active_class`=4. With 0x00 → 0xC0 each.
- CONFIRM=2, scores {200,50,300,10} strobed twice → first COMMIT leaves class none; second sets class 2 at t+6. Pixels after that are 0/0/0xFF.
- Scores {200,200,0,0} → class 0 (tie to lowest). Scores {127,127,127,127} → none after two updates, grey restored.
- Negative scores {-5,-300,…} with THRESHOLD=-10 → class 0 selected, confirming signed compare.
- `score_valid` asserted during SCAN → `score_drop` pulses once, and the result reflects only the first strobe.
- With macro: write class 1 = {0x12,0x34,0x56} while class 1 is active → the next pixel outputs 0x12/0x34/0x56. Assert `rst` mid-scan → all outputs at reset values, `score_busy`=0.
